// File: rtl/w0rm_dvi_pkg.sv
// Shared timing constants, counter sizing and state encoding for the DVI raster generator.
package w0rm_dvi_pkg;

    // 1080p60 raster (148.5 MHz pixel clock)
    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FRONT_1080P  = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BACK_1080P   = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FRONT_1080P  = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BACK_1080P   = 36;

    localparam int H_TOTAL_1080P = H_ACTIVE_1080P + H_FRONT_1080P + H_SYNC_1080P + H_BACK_1080P;
    localparam int V_TOTAL_1080P = V_ACTIVE_1080P + V_FRONT_1080P + V_SYNC_1080P + V_BACK_1080P;

    // 720p60 raster (74.25 MHz pixel clock)
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FRONT_720P  = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BACK_720P   = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FRONT_720P  = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BACK_720P   = 20;

    localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FRONT_720P + H_SYNC_720P + H_BACK_720P;
    localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FRONT_720P + V_SYNC_720P + V_BACK_720P;

    // Counter widths for the default raster
    localparam int H_CNT_W_1080P = $clog2(H_TOTAL_1080P);
    localparam int V_CNT_W_1080P = $clog2(V_TOTAL_1080P);

    // Width needed to count 0..total-1, never narrower than one bit
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dvi_state_e;

endpackage

// File: rtl/w0rm_dvi_delay_line.sv
// Fixed-depth register delay for the video control flags; depth 0 is a plain wire.
module w0rm_dvi_delay_line #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift the flags one stage per clock; reset loads the inactive pattern everywhere
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/w0rm_dvi_timing_generator.sv
// Raster scan generator: issues framebuffer reads and delays sync/valid flags to meet the read data.
module w0rm_dvi_timing_generator
    import w0rm_dvi_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_1080P,
    parameter int H_FRONT     = H_FRONT_1080P,
    parameter int H_SYNC      = H_SYNC_1080P,
    parameter int H_BACK      = H_BACK_1080P,
    parameter int V_ACTIVE    = V_ACTIVE_1080P,
    parameter int V_FRONT     = V_FRONT_1080P,
    parameter int V_SYNC      = V_SYNC_1080P,
    parameter int V_BACK      = V_BACK_1080P,
    parameter bit H_SYNC_POL  = 1'b1,
    parameter bit V_SYNC_POL  = 1'b1,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  cpu_reset,
    input  logic                  timing_enable_i,
    output logic                  fb_read_valid_o,
    output logic [ADDR_WIDTH-1:0] fb_read_addr_o,
    output logic                  dvi_data_valid,
    output logic                  dvi_h_sync,
    output logic                  dvi_v_sync,
    output logic                  frame_start_o,
    output logic                  busy_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        MEM_LATENCY < 0 || MEM_LATENCY > 8) begin : g_param_check
        $error("w0rm_dvi_timing_generator: timing params must be nonzero and MEM_LATENCY in 0..8");
    end

    dvi_state_e            state_q;
    dvi_state_e            state_d;
    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  run;
    logic                  h_last;
    logic                  v_last;
    logic                  frame_last;
    logic                  active_c;
    logic                  hs_c;
    logic                  vs_c;
    logic                  fs_c;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [3:0]            ctrl_p0;
    logic [3:0]            ctrl_dly;

    assign run        = (state_q == RUN);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_last = run && h_last && v_last;

    // State register
    always_ff @(posedge sys_clk) begin
        if (cpu_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start on a sampled enable; stop only at the last pixel of a frame so frames always complete
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (timing_enable_i) state_d = RUN;
            RUN:     if (frame_last && !timing_enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = run;

    // Raster counters: advance in RUN, parked at the origin otherwise
    always_ff @(posedge sys_clk) begin
        if (cpu_reset || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Region decode of the current counter position; everything inactive outside RUN
    always_comb begin
        active_c = 1'b0;
        hs_c     = 1'b0;
        vs_c     = 1'b0;
        fs_c     = 1'b0;
        if (run) begin
            active_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
            hs_c     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            vs_c     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
            fs_c     = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Linear pixel address: steps once per active pixel, rewinds at frame end so no multiplier is needed
    always_ff @(posedge sys_clk) begin
        if (cpu_reset || !run || frame_last) begin
            addr_cnt <= '0;
        end else if (active_c) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
    end

    // ---- stage p0: framebuffer read request and control flags registered together ----
    always_ff @(posedge sys_clk) begin
        if (cpu_reset) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
            ctrl_p0 <= '0;
        end else begin
            vld_p0  <= active_c;
            if (active_c) begin
                addr_p0 <= addr_cnt;
            end
            ctrl_p0 <= {active_c, hs_c, vs_c, fs_c};
        end
    end

    assign fb_read_valid_o = vld_p0;
    assign fb_read_addr_o  = addr_p0;

    // ---- stages p1..: control flags wait out the framebuffer read latency ----
    w0rm_dvi_delay_line #(
        .WIDTH   (4),
        .DEPTH   (MEM_LATENCY),
        .RST_VAL (4'b0000)
    ) u_ctrl_delay (
        .clk  (sys_clk),
        .rst  (cpu_reset),
        .din  (ctrl_p0),
        .dout (ctrl_dly)
    );

    assign dvi_data_valid = ctrl_dly[3];
    assign dvi_h_sync     = ctrl_dly[2] ? H_SYNC_POL : ~H_SYNC_POL;
    assign dvi_v_sync     = ctrl_dly[1] ? V_SYNC_POL : ~V_SYNC_POL;
    assign frame_start_o  = ctrl_dly[0];

endmodule

// File: tb/tb_w0rm_dvi_timing_generator.sv
// Directed bench for the DVI timing generator on a small 8x6 raster.
`timescale 1ns/1ps
module tb_w0rm_dvi_timing_generator;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 8
    localparam int FT = HT * (VA + VF + VS + VB); // 48
    localparam int NPIX = HA * VA;           // 12

    logic sys_clk = 1'b0;
    logic cpu_reset = 1'b1;
    logic timing_enable_i = 1'b0;

    logic        a_rv, a_dv, a_hs, a_vs, a_fs, a_busy;
    logic [31:0] a_addr;
    logic        b_rv, b_dv, b_hs, b_vs, b_fs, b_busy;
    logic [31:0] b_addr;

    always #5 sys_clk = ~sys_clk;

    w0rm_dvi_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .ADDR_WIDTH(32), .MEM_LATENCY(1)
    ) dut_a (
        .sys_clk(sys_clk), .cpu_reset(cpu_reset), .timing_enable_i(timing_enable_i),
        .fb_read_valid_o(a_rv), .fb_read_addr_o(a_addr), .dvi_data_valid(a_dv),
        .dvi_h_sync(a_hs), .dvi_v_sync(a_vs), .frame_start_o(a_fs), .busy_o(a_busy)
    );

    w0rm_dvi_timing_generator #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .ADDR_WIDTH(32), .MEM_LATENCY(3)
    ) dut_b (
        .sys_clk(sys_clk), .cpu_reset(cpu_reset), .timing_enable_i(timing_enable_i),
        .fb_read_valid_o(b_rv), .fb_read_addr_o(b_addr), .dvi_data_valid(b_dv),
        .dvi_h_sync(b_hs), .dvi_v_sync(b_vs), .frame_start_o(b_fs), .busy_o(b_busy)
    );

    int errors = 0;
    int checks = 0;
    int c = 0;                 // cycles since the run started (0 = first cycle in RUN)
    int stop_at = 1 << 30;     // first cycle back in IDLE
    int rd_idx = 0;            // expected read sequence number
    logic [31:0] last_addr = '0;

    task automatic step();
        @(posedge sys_clk);
        #1;
        c++;
    endtask

    // Raster position (0..47) held by the counters in cycle k, or -1 when idle
    function automatic int pos_of(input int k);
        if (k < 0 || k >= stop_at) return -1;
        return k % FT;
    endfunction

    function automatic bit m_act(input int p);
        return (p >= 0) && ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic bit m_hs(input int p);
        return (p >= 0) && ((p % HT) == 5 || (p % HT) == 6);
    endfunction

    function automatic bit m_vs(input int p);
        return (p >= 0) && ((p / HT) == 4);
    endfunction

    task automatic test_reset();
        cpu_reset = 1'b1;
        timing_enable_i = 1'b0;
        repeat (3) step();
        checks++; if (a_hs !== 1'b0)  begin errors++; $display("FAIL reset.h_sync: got %b expected 0", a_hs); end
        checks++; if (a_vs !== 1'b0)  begin errors++; $display("FAIL reset.v_sync: got %b expected 0", a_vs); end
        checks++; if (a_dv !== 1'b0)  begin errors++; $display("FAIL reset.data_valid: got %b expected 0", a_dv); end
        checks++; if (a_rv !== 1'b0)  begin errors++; $display("FAIL reset.read_valid: got %b expected 0", a_rv); end
        checks++; if (a_addr !== 32'd0) begin errors++; $display("FAIL reset.addr: got %0d expected 0", a_addr); end
        checks++; if (a_fs !== 1'b0)  begin errors++; $display("FAIL reset.frame_start: got %b expected 0", a_fs); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset.busy: got %b expected 0", a_busy); end
        checks++; if (b_hs !== 1'b1)  begin errors++; $display("FAIL reset.b_h_sync: got %b expected 1", b_hs); end
        checks++; if (b_vs !== 1'b1)  begin errors++; $display("FAIL reset.b_v_sync: got %b expected 1", b_vs); end
        cpu_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle.busy k=%0d: got %b expected 0", k, a_busy); end
            checks++; if (a_rv !== 1'b0)   begin errors++; $display("FAIL idle.read_valid k=%0d: got %b expected 0", k, a_rv); end
            checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0) begin errors++; $display("FAIL idle.syncs k=%0d: got %b%b expected 00", k, a_hs, a_vs); end
            checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin errors++; $display("FAIL idle.b_syncs k=%0d: got %b%b expected 11", k, b_hs, b_vs); end
            checks++; if (a_addr !== 32'd0) begin errors++; $display("FAIL idle.addr k=%0d: got %0d expected 0", k, a_addr); end
        end
    endtask

    task automatic test_full_frame();
        int p1, p2;
        timing_enable_i = 1'b1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL frame.busy_before_sample: got %b expected 0", a_busy); end
        step();
        c = 0;
        rd_idx = 0;
        last_addr = '0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) step();
            p1 = pos_of(c - 1);
            p2 = pos_of(c - 2);
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL frame.busy c=%0d: got %b expected 1", c, a_busy); end
            checks++; if (a_rv !== m_act(p1)) begin errors++; $display("FAIL frame.read_valid c=%0d: got %b expected %b", c, a_rv, m_act(p1)); end
            if (m_act(p1)) begin
                last_addr = 32'(rd_idx % NPIX);
                rd_idx++;
            end
            checks++; if (a_addr !== last_addr) begin errors++; $display("FAIL frame.addr c=%0d: got %0d expected %0d", c, a_addr, last_addr); end
            checks++; if (a_dv !== m_act(p2)) begin errors++; $display("FAIL frame.data_valid c=%0d: got %b expected %b", c, a_dv, m_act(p2)); end
            checks++; if (a_hs !== m_hs(p2)) begin errors++; $display("FAIL frame.h_sync c=%0d: got %b expected %b", c, a_hs, m_hs(p2)); end
            checks++; if (a_vs !== m_vs(p2)) begin errors++; $display("FAIL frame.v_sync c=%0d: got %b expected %b", c, a_vs, m_vs(p2)); end
            checks++; if (a_fs !== (c == 2 || c == 50 || c == 98)) begin errors++; $display("FAIL frame.frame_start c=%0d: got %b", c, a_fs); end
        end
    endtask

    task automatic test_enable_drop();
        int p1, p2;
        stop_at = 144;   // enable is low when the last pixel of frame 2 (cycle 143) is sampled
        for (int k = 100; k <= 165; k++) begin
            step();
            if (c == 106) timing_enable_i = 1'b0;  // counters at h=2, v=1
            if (c == 120) timing_enable_i = 1'b1;  // re-raised mid-frame
            if (c == 130) timing_enable_i = 1'b0;  // dropped again before the last pixel
            p1 = pos_of(c - 1);
            p2 = pos_of(c - 2);
            checks++; if (a_busy !== (c < 144)) begin errors++; $display("FAIL drop.busy c=%0d: got %b expected %b", c, a_busy, (c < 144)); end
            checks++; if (a_rv !== m_act(p1)) begin errors++; $display("FAIL drop.read_valid c=%0d: got %b expected %b", c, a_rv, m_act(p1)); end
            if (m_act(p1)) begin
                last_addr = 32'(rd_idx % NPIX);
                rd_idx++;
            end
            checks++; if (a_addr !== last_addr) begin errors++; $display("FAIL drop.addr c=%0d: got %0d expected %0d", c, a_addr, last_addr); end
            checks++; if (a_dv !== m_act(p2)) begin errors++; $display("FAIL drop.data_valid c=%0d: got %b expected %b", c, a_dv, m_act(p2)); end
            checks++; if (a_hs !== m_hs(p2) || a_vs !== m_vs(p2)) begin errors++; $display("FAIL drop.syncs c=%0d: got %b%b expected %b%b", c, a_hs, a_vs, m_hs(p2), m_vs(p2)); end
            checks++; if (a_fs !== (p2 == 0)) begin errors++; $display("FAIL drop.frame_start c=%0d: got %b expected %b", c, a_fs, (p2 == 0)); end
        end
    endtask

    task automatic test_restart();
        timing_enable_i = 1'b1;
        step();
        c = 0;
        stop_at = 1 << 30;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL restart.busy c=%0d: got %b expected 1", c, a_busy); end
            checks++; if (a_fs !== (c == 2)) begin errors++; $display("FAIL restart.frame_start c=%0d: got %b expected %b", c, a_fs, (c == 2)); end
            if (c == 1) begin
                checks++; if (a_rv !== 1'b1 || a_addr !== 32'd0) begin errors++; $display("FAIL restart.first_read: got valid=%b addr=%0d expected valid=1 addr=0", a_rv, a_addr); end
            end
        end
    endtask

    task automatic test_polarity_latency();
        int p1, p4;
        cpu_reset = 1'b1;
        repeat (2) step();
        checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) begin errors++; $display("FAIL pol.reset_syncs: got %b%b expected 11", b_hs, b_vs); end
        checks++; if (b_dv !== 1'b0 || b_fs !== 1'b0 || b_rv !== 1'b0) begin errors++; $display("FAIL pol.reset_flags: got dv=%b fs=%b rv=%b expected 000", b_dv, b_fs, b_rv); end
        checks++; if (b_addr !== 32'd0 || b_busy !== 1'b0) begin errors++; $display("FAIL pol.reset_addr_busy: got addr=%0d busy=%b expected 0/0", b_addr, b_busy); end
        cpu_reset = 1'b0;
        step();
        c = 0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) step();
            p1 = pos_of(c - 1);
            p4 = pos_of(c - 4);
            checks++; if (b_rv !== m_act(p1)) begin errors++; $display("FAIL pol.read_valid c=%0d: got %b expected %b", c, b_rv, m_act(p1)); end
            checks++; if (b_dv !== m_act(p4)) begin errors++; $display("FAIL pol.data_valid c=%0d: got %b expected %b", c, b_dv, m_act(p4)); end
            checks++; if (b_hs !== !m_hs(p4)) begin errors++; $display("FAIL pol.h_sync c=%0d: got %b expected %b", c, b_hs, !m_hs(p4)); end
            checks++; if (b_vs !== !m_vs(p4)) begin errors++; $display("FAIL pol.v_sync c=%0d: got %b expected %b", c, b_vs, !m_vs(p4)); end
            checks++; if (b_fs !== (c == 4 || c == 52)) begin errors++; $display("FAIL pol.frame_start c=%0d: got %b", c, b_fs); end
        end
    endtask

    task automatic test_reset_midrun();
        while (c < 65) step();   // cycle 65: counters at h=1, v=2
        cpu_reset = 1'b1;
        step();
        checks++; if (a_rv !== 1'b0 || a_addr !== 32'd0) begin errors++; $display("FAIL midreset.read: got valid=%b addr=%0d expected 0/0", a_rv, a_addr); end
        checks++; if (a_dv !== 1'b0 || a_fs !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midreset.flags: got dv=%b fs=%b busy=%b expected 000", a_dv, a_fs, a_busy); end
        checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0) begin errors++; $display("FAIL midreset.syncs: got %b%b expected 00", a_hs, a_vs); end
        checks++; if (b_dv !== 1'b0 || b_hs !== 1'b1 || b_vs !== 1'b1) begin errors++; $display("FAIL midreset.b_outputs: got dv=%b hs=%b vs=%b expected 0 1 1", b_dv, b_hs, b_vs); end
        cpu_reset = 1'b0;
        step();
        c = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL resume.busy c=%0d: got %b expected 1", c, a_busy); end
            checks++; if (a_fs !== (c == 2)) begin errors++; $display("FAIL resume.frame_start c=%0d: got %b expected %b", c, a_fs, (c == 2)); end
            checks++; if (a_rv !== (c >= 1)) begin errors++; $display("FAIL resume.read_valid c=%0d: got %b expected %b", c, a_rv, (c >= 1)); end
            if (c >= 1) begin
                checks++; if (a_addr !== 32'(c - 1)) begin errors++; $display("FAIL resume.addr c=%0d: got %0d expected %0d", c, a_addr, c - 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_enable_drop();
        test_restart();
        test_polarity_latency();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
